uart_rx_fifo: RTL and testbench

Parametrised UART receiver with an output FIFO and framing/parity checking. It is the next generation of the fixed 8N1 receive path behind `top`'s `serial_rx` pin, and adds configurable baud divisor, data width, parity and stop bits. It also adds a false-start glitch filter and a valid/ready output buffered by a small FIFO, so bytes are not lost while the consumer is busy.

---
 rtl/uart_rx_fifo.sv | 180 ++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// UART receiver with configurable divisor, data width, parity and stop
// bits, plus a false-start filter and a small valid/ready output FIFO.
// Each FIFO entry holds {frame_err, parity_err, data}.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 10,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 serial_rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = DATA_BITS + 2;

    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic          PAR_ODD   = (PARITY == 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic                 sync1, sync2, prev;
    logic                 start_det;
    logic [2:0]           state;
    logic [CW-1:0]        cnt;
    logic [BW-1:0]        bit_idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 perr;
    logic                 ferr;
    logic                 tick;
    logic                 push;
    logic [EW-1:0]        entry;

    logic [EW-1:0]        mem [FIFO_DEPTH];
    logic [AW:0]          wptr, rptr;
    logic                 empty, full, pop, do_write;

    // Two-stage synchroniser plus previous-value flop for edge detection
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            prev  <= 1'b1;
        end else begin
            sync1 <= serial_rx;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign start_det = prev & ~sync2;
    assign tick      = (cnt == BIT_LAST);
    // The last stop sample pushes; the stop sample itself folds into frame_err.
    assign push      = (state == S_STOP) && tick && (stop_idx == STOP_LAST);
    assign entry     = {ferr | ~sync2, perr, shreg};

    // Receive FSM: mid-bit sampling driven by a per-bit cycle counter
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            shreg    <= '0;
            perr     <= 1'b0;
            ferr     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_det) begin
                        state <= S_START;
                        cnt   <= '0;
                    end
                end
                S_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt      <= '0;
                        bit_idx  <= '0;
                        stop_idx <= 1'b0;
                        perr     <= 1'b0;
                        ferr     <= 1'b0;
                        state    <= sync2 ? S_IDLE : S_DATA;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        cnt   <= '0;
                        shreg <= {sync2, shreg[DATA_BITS-1:1]};
                        if (bit_idx == DATA_LAST) begin
                            state <= (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            bit_idx <= bit_idx + BW'(1);
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_PARITY: begin
                    if (tick) begin
                        cnt   <= '0;
                        perr  <= ((^shreg) ^ sync2) != PAR_ODD;
                        state <= S_STOP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_STOP: begin
                    if (tick) begin
                        cnt  <= '0;
                        ferr <= ferr | ~sync2;
                        if (stop_idx == STOP_LAST) begin
                            state <= S_IDLE;
                        end else begin
                            stop_idx <= stop_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign empty    = (wptr == rptr);
    assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign pop      = !empty && rx_ready;
    // A pop in the same cycle frees the slot, so a push into a full FIFO proceeds.
    assign do_write = push && (!full || pop);

    // FIFO storage; cleared on reset so the head reads zero afterwards
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_write) begin
            mem[wptr[AW-1:0]] <= entry;
        end
    end

    // FIFO pointers and the overrun pulse for dropped frames
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wptr    <= '0;
            rptr    <= '0;
            overrun <= 1'b0;
        end else begin
            if (do_write) wptr <= wptr + (AW+1)'(1);
            if (pop)      rptr <= rptr + (AW+1)'(1);
            overrun <= push && full && !pop;
        end
    end

    assign {rx_frame_err, rx_parity_err, rx_data} = mem[rptr[AW-1:0]];
    assign rx_valid = !empty;
    assign busy     = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: a queue model of expected FIFO
// contents checked every cycle, plus directed literal checks.
module tb_uart_rx_fifo;

    localparam int CPB   = 10;
    localparam int DEPTH = 4;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       serial_rx = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_parity_err, rx_frame_err, rx_valid, overrun, busy;

    logic       serial_p = 1'b1;
    logic       ready_p = 1'b0;
    logic [7:0] data_p;
    logic       perr_p, ferr_p, valid_p, overrun_p, busy_p;

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0),
                   .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) dut (
        .clock(clock), .reset_n(reset_n), .serial_rx(serial_rx),
        .rx_data(rx_data), .rx_parity_err(rx_parity_err),
        .rx_frame_err(rx_frame_err), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .overrun(overrun), .busy(busy));

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2),
                   .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) dut_p (
        .clock(clock), .reset_n(reset_n), .serial_rx(serial_p),
        .rx_data(data_p), .rx_parity_err(perr_p),
        .rx_frame_err(ferr_p), .rx_valid(valid_p),
        .rx_ready(ready_p), .overrun(overrun_p), .busy(busy_p));

    always #10 clock = ~clock;

    int errors = 0;
    int checks = 0;
    int exp_overruns = 0;
    int seen_overruns = 0;
    logic [9:0] model_q [$];
    logic [9:0] pop_log [$];
    logic [9:0] exp_log [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Model: entries expected in the FIFO, {frame_err, parity_err, data}.
    // Checked every cycle the DUT head is valid; popped when the DUT pops.
    initial begin
        forever begin
            @(negedge clock);
            #5;
            if (!reset_n) begin
                model_q.delete();
            end else begin
                if (overrun) seen_overruns++;
                if (rx_valid) begin
                    if (model_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL head_vs_model: DUT head 0x%0h valid, model expects empty",
                                 {rx_frame_err, rx_parity_err, rx_data});
                    end else begin
                        check("head_vs_model", 32'({rx_frame_err, rx_parity_err, rx_data}),
                              32'(model_q[0]));
                        if (rx_ready) begin
                            pop_log.push_back({rx_frame_err, rx_parity_err, rx_data});
                            void'(model_q.pop_front());
                        end
                    end
                end
            end
        end
    end

    task automatic set_line(input bit which, input logic v);
        if (which) serial_p = v;
        else       serial_rx = v;
    endtask

    task automatic hold_bit(input bit which, input logic v);
        set_line(which, v);
        repeat (CPB) @(negedge clock);
    endtask

    // par < 0: no parity bit; otherwise par[0] is sent as the parity bit.
    task automatic send_frame(input bit which, input logic [7:0] d, input int par,
                              input logic stop_v, input bit drop);
        @(negedge clock);
        hold_bit(which, 1'b0);
        for (int i = 0; i < 8; i++) hold_bit(which, d[i]);
        if (par >= 0) hold_bit(which, par[0]);
        if (!which) begin
            if (drop) exp_overruns++;
            else      model_q.push_back({~stop_v, 1'b0, d});
        end
        hold_bit(which, stop_v);
    endtask

    task automatic wait_drained(input string name);
        int n = 0;
        while (rx_valid && n < 400) begin
            @(negedge clock);
            n++;
        end
        repeat (2) @(negedge clock);
        check({name, "_valid_low"}, 32'(rx_valid), 32'd0);
        check({name, "_model_empty"}, 32'(model_q.size()), 32'd0);
    endtask

    task automatic check_log(input string name);
        check({name, "_pop_count"}, 32'(pop_log.size()), 32'(exp_log.size()));
        for (int i = 0; i < exp_log.size() && i < pop_log.size(); i++)
            check($sformatf("%s_pop%0d", name, i), 32'(pop_log[i]), 32'(exp_log[i]));
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        logic [7:0] pd;
        bit         any_valid;

        // Reset state
        repeat (3) @(negedge clock);
        check("rst_valid", 32'(rx_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_data", 32'(rx_data), 32'd0);
        check("rst_flags", 32'({rx_frame_err, rx_parity_err}), 32'd0);
        reset_n = 1'b1;
        repeat (5) @(negedge clock);

        // Back-to-back clean frames, consumer always ready
        rx_ready = 1'b1;
        pop_log.delete();
        seen_overruns = 0;
        exp_overruns = 0;
        for (int d = 8'hAC; d <= 8'hB0; d++) begin
            send_frame(1'b0, 8'(d), -1, 1'b1, 1'b0);
            repeat (50) @(negedge clock);
        end
        wait_drained("clean");
        exp_log = {10'h0AC, 10'h0AD, 10'h0AE, 10'h0AF, 10'h0B0};
        check_log("clean");
        check("clean_overruns", 32'(seen_overruns), 32'(exp_overruns));

        // Glitch: low for three clocks
        @(negedge clock);
        serial_rx = 1'b0;
        repeat (2) @(negedge clock);
        check("glitch_busy_before", 32'(busy), 32'd0);
        @(negedge clock);
        serial_rx = 1'b1;
        check("glitch_busy_latency", 32'(busy), 32'd1);
        repeat (4) @(negedge clock);
        check("glitch_busy_held", 32'(busy), 32'd1);
        @(negedge clock);
        check("glitch_busy_drop", 32'(busy), 32'd0);
        any_valid = 1'b0;
        repeat (150) begin
            @(negedge clock);
            if (rx_valid || busy) any_valid = 1'b1;
        end
        check("glitch_no_push", 32'(any_valid), 32'd0);

        // Even parity on the second instance: 0x5A has four ones, parity bit should be 0
        send_frame(1'b1, 8'h5A, 1, 1'b1, 1'b0);
        repeat (5) @(negedge clock);
        check("par_bad_valid", 32'(valid_p), 32'd1);
        check("par_bad_entry", 32'({ferr_p, perr_p, data_p}), 32'h15A);
        ready_p = 1'b1;
        @(negedge clock);
        ready_p = 1'b0;
        check("par_popped", 32'(valid_p), 32'd0);
        send_frame(1'b1, 8'h5A, 0, 1'b1, 1'b0);
        repeat (5) @(negedge clock);
        check("par_good_entry", 32'({valid_p, ferr_p, perr_p, data_p}), 32'h45A);
        ready_p = 1'b1;
        @(negedge clock);
        ready_p = 1'b0;

        // Framing error followed by a long break, then a clean frame
        pop_log.delete();
        send_frame(1'b0, 8'h33, -1, 1'b0, 1'b0);
        repeat (30 * CPB) @(negedge clock);
        check("break_busy", 32'(busy), 32'd0);
        serial_rx = 1'b1;
        repeat (2 * CPB) @(negedge clock);
        send_frame(1'b0, 8'h0F, -1, 1'b1, 1'b0);
        repeat (50) @(negedge clock);
        wait_drained("break");
        exp_log = {10'h233, 10'h00F};
        check_log("break");

        // Overrun: consumer stalled, fifth frame dropped
        rx_ready = 1'b0;
        pop_log.delete();
        seen_overruns = 0;
        exp_overruns = 0;
        for (int d = 8'hAC; d <= 8'hB0; d++) begin
            send_frame(1'b0, 8'(d), -1, 1'b1, (d == 8'hB0));
            repeat (20) @(negedge clock);
        end
        check("ovr_pulses", 32'(seen_overruns), 32'(exp_overruns));
        check("ovr_pulses_lit", 32'(seen_overruns), 32'd1);
        rx_ready = 1'b1;
        wait_drained("ovr");
        exp_log = {10'h0AC, 10'h0AD, 10'h0AE, 10'h0AF};
        check_log("ovr");

        // Full FIFO with a pop in exactly the push cycle: no overrun
        rx_ready = 1'b0;
        pop_log.delete();
        seen_overruns = 0;
        exp_overruns = 0;
        for (int d = 1; d <= 4; d++) begin
            send_frame(1'b0, 8'(d), -1, 1'b1, 1'b0);
            repeat (20) @(negedge clock);
        end
        fork
            send_frame(1'b0, 8'h05, -1, 1'b1, 1'b0);
            begin
                @(negedge clock);
                repeat (97) @(negedge clock);
                rx_ready = 1'b1;
                @(negedge clock);
                rx_ready = 1'b0;
            end
        join
        repeat (20) @(negedge clock);
        check("same_cycle_overruns", 32'(seen_overruns), 32'd0);
        check("same_cycle_valid", 32'(rx_valid), 32'd1);
        rx_ready = 1'b1;
        wait_drained("same_cycle");
        exp_log = {10'h001, 10'h002, 10'h003, 10'h004, 10'h005};
        check_log("same_cycle");

        // Reset during data bit 3 flushes the FIFO and abandons the frame
        rx_ready = 1'b0;
        send_frame(1'b0, 8'h11, -1, 1'b1, 1'b0);
        repeat (20) @(negedge clock);
        check("pre_reset_valid", 32'(rx_valid), 32'd1);
        pd = 8'h55;
        @(negedge clock);
        hold_bit(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) hold_bit(1'b0, pd[i]);
        serial_rx = pd[3];
        repeat (CPB / 2) @(negedge clock);
        check("mid_frame_busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        serial_rx = 1'b1;
        check("mid_rst_valid", 32'(rx_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_data", 32'(rx_data), 32'd0);
        repeat (2 * CPB) @(negedge clock);
        check("mid_rst_idle_busy", 32'(busy), 32'd0);
        rx_ready = 1'b1;
        pop_log.delete();
        send_frame(1'b0, 8'h3C, -1, 1'b1, 1'b0);
        repeat (50) @(negedge clock);
        wait_drained("after_rst");
        exp_log = {10'h03C};
        check_log("after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
